// File: rtl/melody_sequencer_pkg.sv
// melody_sequencer_pkg: note codes, tone dividers, sequencer states and code-to-divider mapping
package melody_sequencer_pkg;
  localparam logic [3:0] REST = 4'd0;
  localparam logic [3:0] LO_C = 4'd1;
  localparam logic [3:0] LO_D = 4'd2;
  localparam logic [3:0] LO_E = 4'd3;
  localparam logic [3:0] LO_F = 4'd4;
  localparam logic [3:0] LO_G = 4'd5;
  localparam logic [3:0] LO_A = 4'd6;
  localparam logic [3:0] LO_B = 4'd7;
  localparam logic [3:0] HI_C = 4'd9;
  localparam logic [3:0] HI_D = 4'd10;
  localparam logic [3:0] HI_E = 4'd11;
  localparam logic [3:0] HI_F = 4'd12;
  localparam logic [3:0] HI_G = 4'd13;
  localparam logic [3:0] HI_A = 4'd14;
  localparam logic [3:0] HI_B = 4'd15;
  localparam logic [21:0] DIV_LO_C = 22'd191570;
  localparam logic [21:0] DIV_LO_D = 22'd170648;
  localparam logic [21:0] DIV_LO_E = 22'd151515;
  localparam logic [21:0] DIV_LO_F = 22'd143266;
  localparam logic [21:0] DIV_LO_G = 22'd127551;
  localparam logic [21:0] DIV_LO_A = 22'd113636;
  localparam logic [21:0] DIV_LO_B = 22'd101215;
  localparam logic [21:0] DIV_HI_C = 22'd95420;
  localparam logic [21:0] DIV_HI_D = 22'd85034;
  localparam logic [21:0] DIV_HI_E = 22'd75758;
  localparam logic [21:0] DIV_HI_F = 22'd71633;
  localparam logic [21:0] DIV_HI_G = 22'd63776;
  localparam logic [21:0] DIV_HI_A = 22'd56818;
  localparam logic [21:0] DIV_HI_B = 22'd50607;
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;
  // codes 0 and 8 (and anything unlisted) are rests
  function automatic logic [21:0] code_div(input logic [3:0] code);
    case (code)
      LO_C: code_div = DIV_LO_C;
      LO_D: code_div = DIV_LO_D;
      LO_E: code_div = DIV_LO_E;
      LO_F: code_div = DIV_LO_F;
      LO_G: code_div = DIV_LO_G;
      LO_A: code_div = DIV_LO_A;
      LO_B: code_div = DIV_LO_B;
      HI_C: code_div = DIV_HI_C;
      HI_D: code_div = DIV_HI_D;
      HI_E: code_div = DIV_HI_E;
      HI_F: code_div = DIV_HI_F;
      HI_G: code_div = DIV_HI_G;
      HI_A: code_div = DIV_HI_A;
      HI_B: code_div = DIV_HI_B;
      default: code_div = 22'd0;
    endcase
  endfunction
endpackage

// File: rtl/melody_rom.sv
// melody_rom: combinational 64x6 song table, entry = {dur[1:0], code[3:0]}; entries past 31 are rests
import melody_sequencer_pkg::*;
module melody_rom (
  input  logic [5:0] idx,
  output logic [5:0] entry
);
  localparam logic [5:0] SONG [32] = '{
    {2'd0, LO_C}, {2'd1, HI_E}, {2'd0, REST}, {2'd0, LO_G},
    {2'd0, LO_G}, {2'd0, LO_A}, {2'd0, LO_A}, {2'd1, LO_G},
    {2'd0, LO_F}, {2'd0, LO_F}, {2'd0, LO_E}, {2'd0, LO_E},
    {2'd0, LO_D}, {2'd0, LO_D}, {2'd1, LO_C}, {2'd0, REST},
    {2'd0, HI_C}, {2'd0, HI_C}, {2'd0, HI_G}, {2'd0, HI_G},
    {2'd0, HI_A}, {2'd0, HI_A}, {2'd1, HI_G}, {2'd0, HI_F},
    {2'd0, HI_F}, {2'd0, HI_E}, {2'd0, HI_E}, {2'd0, HI_D},
    {2'd0, HI_D}, {2'd3, HI_C}, {2'd0, REST}, {2'd0, REST}
  };
  assign entry = idx[5] ? 6'd0 : SONG[idx[4:0]];
endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: play/pause/stop melody player with tempo select; MELODY_SEQUENCER_GAP_EN adds a silent tail to each note
import melody_sequencer_pkg::*;
module melody_sequencer #(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int SONG_LEN = 32,
  parameter int GAP_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [1:0]  tempo_sel,
  output logic [21:0] note_div,
  output logic [5:0]  note_idx,
  output logic        playing,
  output logic        done
);
  localparam int CW = $clog2(BEAT_CYCLES + 1);
`ifdef MELODY_SEQUENCER_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  state_t state, nxt_state;
  logic [CW-1:0] cyc, nxt_cyc, len, nxt_len, tempo_len;
  logic [1:0] beat, nxt_beat, cur_dur, rom_dur;
  logic [5:0] nxt_idx, entry;
  logic [3:0] rom_code;
  logic fin, silent;
  assign {rom_dur, rom_code} = entry;
  assign tempo_len = CW'(BEAT_CYCLES) >> (tempo_sel[1] ? 2'd2 : tempo_sel);
  assign silent = GAP_EN && nxt_beat == rom_dur && nxt_cyc >= nxt_len - CW'(GAP_CYCLES);
  // the ROM looks up the entry about to become current so outputs stay aligned with note_idx
  melody_rom u_rom (.idx(nxt_idx), .entry(entry));
  // next-state: beat timing in PLAY, then button transitions, with stop overriding everything
  always_comb begin
    nxt_state = state;
    nxt_idx = note_idx;
    nxt_cyc = cyc;
    nxt_beat = beat;
    nxt_len = len;
    fin = 1'b0;
    if (state == PLAY) begin
      if (cyc == len - CW'(1)) begin
        nxt_cyc = '0;
        nxt_len = tempo_len;
        if (beat == cur_dur) begin
          nxt_beat = '0;
          if (note_idx == 6'(SONG_LEN - 1)) begin
            nxt_idx = '0;
            fin = !loop_en;
            nxt_state = loop_en ? PLAY : IDLE;
          end else
            nxt_idx = note_idx + 6'd1;
        end else
          nxt_beat = beat + 2'd1;
      end else
        nxt_cyc = cyc + CW'(1);
    end
    if (play && !fin) begin
      nxt_state = (state == PLAY) ? PAUSE : PLAY;
      if (state == IDLE) nxt_len = tempo_len;
    end
    if (stop) begin
      nxt_state = IDLE;
      nxt_idx = '0;
      nxt_cyc = '0;
      nxt_beat = '0;
      fin = 1'b0;
    end
  end
  // register state, counters and all outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      note_idx <= '0;
      cyc <= '0;
      beat <= '0;
      len <= CW'(BEAT_CYCLES);
      cur_dur <= '0;
      note_div <= '0;
      playing <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt_state;
      note_idx <= nxt_idx;
      cyc <= nxt_cyc;
      beat <= nxt_beat;
      len <= nxt_len;
      cur_dur <= rom_dur;
      note_div <= (nxt_state == PLAY && !silent) ? code_div(rom_code) : 22'd0;
      playing <= nxt_state == PLAY;
      done <= fin;
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: table-driven checks of play, loop, pause, stop and tempo, plus async reset and gap sequences
module tb_melody_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic play = 1'b0;
  logic stop = 1'b0;
  logic loop_en = 1'b0;
  logic [1:0] tempo_sel = 2'd0;
  logic [21:0] note_div;
  logic [5:0] note_idx;
  logic playing, done;
  int compared = 0;
  int mismatched = 0;
  typedef struct {
    logic play, stop, loop_en;
    logic [1:0] tempo;
    int n;
    logic [21:0] div;
    logic [5:0] idx;
    logic playing, done;
  } vec_t;
  vec_t v[$];

  melody_sequencer #(.BEAT_CYCLES(8), .SONG_LEN(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .play(play), .stop(stop), .loop_en(loop_en),
    .tempo_sel(tempo_sel), .note_div(note_div), .note_idx(note_idx),
    .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  task automatic add(input logic p, s, l, input logic [1:0] t, input int n,
                     input logic [21:0] d, input logic [5:0] i, input logic pl, dn);
    vec_t x;
    x.play = p; x.stop = s; x.loop_en = l; x.tempo = t; x.n = n;
    x.div = d; x.idx = i; x.playing = pl; x.done = dn;
    v.push_back(x);
  endtask

  task automatic check(input string name, input logic [21:0] d, input logic [5:0] i, input logic pl, dn);
    compared++;
    if (note_div !== d || note_idx !== i || playing !== pl || done !== dn) begin
      mismatched++;
      $display("FAIL %s: got div=%0d idx=%0d playing=%b done=%b, expected div=%0d idx=%0d playing=%b done=%b",
               name, note_div, note_idx, playing, done, d, i, pl, dn);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      play = 1'b0;
      stop = 1'b0;
    end
  endtask

  initial begin
    // full run, loop_en=0
    add(1, 0, 0, 0, 1, 191570, 0, 1, 0);
    add(0, 0, 0, 0, 7, 191570, 0, 1, 0);
    add(0, 0, 0, 0, 1, 75758, 1, 1, 0);
    add(0, 0, 0, 0, 15, 75758, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 2, 1, 0);
    add(0, 0, 0, 0, 7, 0, 2, 1, 0);
    add(0, 0, 0, 0, 1, 127551, 3, 1, 0);
    add(0, 0, 0, 0, 7, 127551, 3, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // looping
    add(1, 0, 1, 0, 1, 191570, 0, 1, 0);
    add(0, 0, 1, 0, 39, 127551, 3, 1, 0);
    add(0, 0, 1, 0, 1, 191570, 0, 1, 0);
    add(0, 0, 1, 0, 39, 127551, 3, 1, 0);
    add(0, 0, 1, 0, 1, 191570, 0, 1, 0);
    // play and stop together: stop wins
    add(1, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 3, 0, 0, 0, 0);
    // pause three cycles into entry 1, resume for the remaining 13
    add(1, 0, 0, 0, 1, 191570, 0, 1, 0);
    add(0, 0, 0, 0, 8, 75758, 1, 1, 0);
    add(0, 0, 0, 0, 2, 75758, 1, 1, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 20, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 75758, 1, 1, 0);
    add(0, 0, 0, 0, 12, 75758, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 2, 1, 0);
    // tempo change mid-beat takes effect on the next beat
    add(0, 1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 191570, 0, 1, 0);
    add(0, 0, 0, 1, 3, 191570, 0, 1, 0);
    add(0, 0, 0, 1, 4, 191570, 0, 1, 0);
    add(0, 0, 0, 1, 1, 75758, 1, 1, 0);
    add(0, 0, 0, 1, 7, 75758, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0, 2, 1, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1);
`ifdef MELODY_SEQUENCER_GAP_EN
    play = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1);
      check($sformatf("gap%0d", k), k < 6 ? 22'd191570 : 22'd0, 0, 1, 0);
    end
    step(1);
    check("gap_next", 75758, 1, 1, 0);
    stop = 1'b1;
    step(1);
`else
    foreach (v[i]) begin
      play = v[i].play;
      stop = v[i].stop;
      loop_en = v[i].loop_en;
      tempo_sel = v[i].tempo;
      step(v[i].n);
      check($sformatf("vec%0d", i), v[i].div, v[i].idx, v[i].playing, v[i].done);
    end
`endif
    // asynchronous reset in the middle of a note
    loop_en = 1'b0;
    tempo_sel = 2'd0;
    play = 1'b1;
    step(3);
    check("pre_rst", 191570, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", 0, 0, 0, 0);
    step(1);
    rst_n = 1'b1;
    step(2);
    check("post_rst", 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
